uart_tx_regs: RTL and testbench

- Register-mapped UART transmit block, directly downstream of the APB slave bridge.
- Consumes the bridge's UART-side request (w_en, r_en, addr, w_data) and returns ready, r_data and slverr.
- Holds the baud divisor, control and status registers and an 8-deep TX FIFO, and serialises bytes onto the tx line as 8N1.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_tx_regs.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_regs.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART transmit block shared definitions.
// Register offsets, bit positions and FSM state types.
package uart_pkg;

  localparam logic [7:0] TX_DATA_OFS  = 8'h00;
  localparam logic [7:0] STATUS_OFS   = 8'h04;
  localparam logic [7:0] BAUD_DIV_OFS = 8'h08;
  localparam logic [7:0] CTRL_OFS     = 8'h0C;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic {
    ACC_IDLE,
    ACC_ACK
  } acc_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter.
// Pointers carry an extra wrap bit to tell full from empty.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wptr[AW-1:0]] <= wdata;
  end

  // flush wins over a same-cycle pop or push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + 1'b1;
      if (pop && !empty)
        rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_regs.sv
// Register-mapped 8N1 UART transmitter behind the APB bridge.
// One wait-state access FSM, TX FIFO and serialiser.
module uart_tx_regs
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic        ready,
  output logic [31:0] r_data,
  output logic        slverr,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  acc_state_t  acc_st;
  logic [31:0] a_q;
  logic [15:0] d_q;
  logic        wr_q;
  logic [15:0] div_q;
  logic        en_q;

  tx_state_t   tx_st;
  logic [7:0]  sh;
  logic [2:0]  bcnt;
  logic [15:0] bdiv;
  logic [15:0] baud;

  logic          f_full;
  logic          f_empty;
  logic [7:0]    f_rdata;
  logic [CW-1:0] f_count;
  logic          f_push;
  logic          f_pop;
  logic          f_flush;

  logic        hi_ok;
  logic        hit_tx;
  logic        hit_st;
  logic        hit_div;
  logic        hit_ctl;
  logic        err;
  logic        commit;
  logic        busy;
  logic        adv;
  logic [31:0] status;
  logic [31:0] rd;

  logic unused_ok;
  assign unused_ok = ^w_data[31:16];

  assign busy = (tx_st != TX_IDLE);
  assign adv  = (baud == 16'd0);

  always_comb begin
    hi_ok   = (a_q[31:8] == 24'd0);
    hit_tx  = hi_ok && (a_q[7:0] == TX_DATA_OFS);
    hit_st  = hi_ok && (a_q[7:0] == STATUS_OFS);
    hit_div = hi_ok && (a_q[7:0] == BAUD_DIV_OFS);
    hit_ctl = hi_ok && (a_q[7:0] == CTRL_OFS);
  end

  always_comb begin
    status = '0;
    status[ST_FULL]          = f_full;
    status[ST_EMPTY]         = f_empty;
    status[ST_BUSY]          = busy;
    status[ST_CNT_LSB +: 4]  = 4'(f_count);
  end

  // full is judged on the current cycle, ahead of any same-edge pop
  always_comb begin
    err = 1'b0;
    rd  = '0;
    unique case (1'b1)
      hit_tx:  err = !wr_q || f_full;
      hit_st: begin
        err = wr_q;
        rd  = status;
      end
      hit_div: begin
        err = wr_q && (d_q < DIV_MIN);
        rd  = {16'd0, div_q};
      end
      hit_ctl: rd = {31'd0, en_q};
      default: err = 1'b1;
    endcase
  end

  assign commit  = ready && wr_q && !err;
  assign f_push  = commit && hit_tx;
  assign f_flush = commit && hit_ctl && w_q_flush();
  assign r_data  = (ready && !wr_q && !err) ? rd : '0;
  assign slverr  = ready && err;

  function automatic logic w_q_flush();
    return d_q[CTRL_FLUSH];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_st <= ACC_IDLE;
      ready  <= 1'b0;
      a_q    <= '0;
      d_q    <= '0;
      wr_q   <= 1'b0;
      div_q  <= DIV_RESET;
      en_q   <= 1'b0;
    end else begin
      unique case (acc_st)
        ACC_IDLE: begin
          if (sel && (w_en || r_en)) begin
            acc_st <= ACC_ACK;
            ready  <= 1'b1;
            a_q    <= addr;
            d_q    <= w_data[15:0];
            wr_q   <= w_en;
          end
        end
        ACC_ACK: begin
          acc_st <= ACC_IDLE;
          ready  <= 1'b0;
          if (commit && hit_div)
            div_q <= d_q;
          if (commit && hit_ctl)
            en_q <= d_q[CTRL_EN];
        end
      endcase
    end
  end

  assign f_pop = en_q && !f_empty &&
                 ((tx_st == TX_IDLE) ||
                  ((tx_st == TX_STOP) && adv));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st <= TX_IDLE;
      tx    <= 1'b1;
      sh    <= '0;
      bcnt  <= '0;
      bdiv  <= '0;
      baud  <= '0;
    end else begin
      unique case (tx_st)
        TX_IDLE: begin
          if (f_pop) begin
            sh    <= f_rdata;
            bdiv  <= div_q;
            baud  <= div_q - 16'd1;
            tx    <= 1'b0;
            tx_st <= TX_START;
          end
        end
        TX_START: begin
          if (adv) begin
            baud  <= bdiv - 16'd1;
            tx    <= sh[0];
            sh    <= sh >> 1;
            bcnt  <= '0;
            tx_st <= TX_DATA;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        TX_DATA: begin
          if (adv) begin
            baud <= bdiv - 16'd1;
            if (bcnt == 3'd7) begin
              tx    <= 1'b1;
              tx_st <= TX_STOP;
            end else begin
              tx   <= sh[0];
              sh   <= sh >> 1;
              bcnt <= bcnt + 3'd1;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        TX_STOP: begin
          if (adv) begin
            if (f_pop) begin
              sh    <= f_rdata;
              bdiv  <= div_q;
              baud  <= div_q - 16'd1;
              tx    <= 1'b0;
              tx_st <= TX_START;
            end else begin
              tx    <= 1'b1;
              tx_st <= TX_IDLE;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
      endcase
    end
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .wdata (d_q[7:0]),
    .pop   (f_pop),
    .flush (f_flush),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

endmodule

// File: tb/tb_uart_tx_regs.sv
// Scoreboard bench for uart_tx_regs: bus responses and
// serial frames are checked against a queue-based model.
module tb_uart_tx_regs;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] w_data = '0;
  logic        ready;
  logic [31:0] r_data;
  logic        slverr;
  logic        tx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_regs #(
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (16'd434)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .w_en   (w_en),
    .r_en   (r_en),
    .addr   (addr),
    .w_data (w_data),
    .ready  (ready),
    .r_data (r_data),
    .slverr (slverr),
    .tx     (tx)
  );

  typedef struct {
    bit          err;
    logic [31:0] rd;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  // reference model state
  logic [7:0] mq[$];
  int         div_m = 434;
  bit         en_m = 1'b0;

  // serial monitor state
  bit         in_frame = 1'b0;
  int         cyc = 0;
  int         fdiv = 1;
  logic [7:0] fbyte = '0;
  bit         ferr = 1'b0;
  int         fbad_cyc = 0;
  logic       fbad_val = 1'b0;
  int         idx = 0;
  logic       expb = 1'b1;
  longint     cycle_no = 0;
  longint     starts[$];

  function automatic logic [31:0] status_m();
    int n;
    n = mq.size();
    return {20'd0, 4'(n), 5'd0, in_frame, (n == 0), (n == DEPTH)};
  endfunction

  task automatic predict(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output bit err,
                         output logic [31:0] rd);
    err = 1'b0;
    rd  = '0;
    if (a[31:8] != 24'd0) begin
      err = 1'b1;
    end else begin
      case (a[7:0])
        8'h00: begin
          if (!wr) err = 1'b1;
          else if (mq.size() >= DEPTH) err = 1'b1;
          else mq.push_back(d[7:0]);
        end
        8'h04: begin
          if (wr) err = 1'b1;
          else rd = status_m();
        end
        8'h08: begin
          if (wr) begin
            if (d[15:0] < 16'd2) err = 1'b1;
            else div_m = int'(d[15:0]);
          end else begin
            rd = div_m;
          end
        end
        8'h0C: begin
          if (wr) begin
            en_m = d[0];
            if (d[1]) mq.delete();
          end else begin
            rd = {31'd0, en_m};
          end
        end
        default: err = 1'b1;
      endcase
    end
  endtask

  // bus monitor
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready: slverr=%0b r_data=%h with no access pending",
                 slverr, r_data);
      end else begin
        e_mon = exp_q.pop_front();
        if (slverr !== e_mon.err || r_data !== e_mon.rd) begin
          failures++;
          $display("FAIL %s: got slverr=%0b r_data=%h, required slverr=%0b r_data=%h",
                   e_mon.name, slverr, r_data, e_mon.err, e_mon.rd);
        end
      end
    end else begin
      checks++;
      if (r_data !== 32'd0 || slverr !== 1'b0) begin
        failures++;
        $display("FAIL idle_outputs: got slverr=%0b r_data=%h while ready=0, required 0",
                 slverr, r_data);
      end
    end
  end

  // serial monitor
  always @(negedge clk) begin
    cycle_no++;
    if (rst !== 1'b1) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        checks++;
        if (mq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_start: start bit at cycle %0d with nothing queued",
                   cycle_no);
          fbyte = 8'h00;
        end else begin
          fbyte = mq.pop_front();
        end
        fdiv = div_m;
        cyc = 0;
        ferr = 1'b0;
        in_frame = 1'b1;
        starts.push_back(cycle_no);
      end
      if (in_frame) begin
        idx = cyc / fdiv;
        if (idx == 0) expb = 1'b0;
        else if (idx == 9) expb = 1'b1;
        else expb = fbyte[idx-1];
        if (tx !== expb && !ferr) begin
          ferr = 1'b1;
          fbad_cyc = cyc;
          fbad_val = tx;
        end
        cyc++;
        if (cyc == 10 * fdiv) begin
          in_frame = 1'b0;
          checks++;
          if (ferr) begin
            failures++;
            $display("FAIL frame_%h: div %0d, tx=%b at frame clock %0d, required %b",
                     fbyte, fdiv, fbad_val, fbad_cyc, ~fbad_val);
          end
        end
      end
    end
  end

  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input string nm);
    exp_t e;
    @(negedge clk);
    predict(wr, a, d, e.err, e.rd);
    e.name = nm;
    exp_q.push_back(e);
    sel = 1'b1;
    w_en = wr;
    r_en = rd;
    addr = a;
    w_data = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    w_en = 1'b0;
    r_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input string nm);
    access(1'b1, 1'b0, a, d, nm);
  endtask

  task automatic rd32(input logic [31:0] a, input string nm);
    access(1'b0, 1'b1, a, 32'd0, nm);
  endtask

  task automatic model_reset();
    mq.delete();
    div_m = 434;
    en_m = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while ((in_frame || mq.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (in_frame || mq.size() != 0) begin
      failures++;
      $display("FAIL %s: timeout with in_frame=%0b pending=%0d, required all sent",
               nm, in_frame, mq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  int          n_b;
  int          dv;
  int          w;
  logic [31:0] a_r;
  logic [31:0] d_r;

  initial begin
    #2;
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL in_reset: tx=%b ready=%b, required tx=1 ready=0", tx, ready);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: tx=%b ready=%b, required tx=1 ready=0", tx, ready);
    end
    rd32(32'h08, "rst_baud");
    rd32(32'h0C, "rst_ctrl");
    rd32(32'h04, "rst_status");

    // single frame
    wr32(32'h08, 32'd4, "basic_baud");
    wr32(32'h0C, 32'd1, "basic_en");
    wr32(32'h00, 32'hA5, "basic_push");
    repeat (10) @(negedge clk);
    rd32(32'h04, "busy_status");
    wait_done(200, "basic_frame");
    rd32(32'h04, "status_after_frame");

    // fill to full
    wr32(32'h0C, 32'd0, "fill_dis");
    for (int i = 0; i < DEPTH; i++)
      wr32(32'h00, $urandom, "fill_push");
    wr32(32'h00, $urandom, "push_full");
    rd32(32'h04, "status_full");

    // flush then two back-to-back frames
    wr32(32'h0C, 32'd2, "flush");
    rd32(32'h04, "status_flushed");
    wr32(32'h00, $urandom, "b2b_push0");
    wr32(32'h00, $urandom, "b2b_push1");
    starts.delete();
    wr32(32'h0C, 32'd1, "b2b_en");
    wait_done(300, "b2b_frames");
    checks++;
    if (starts.size() != 2) begin
      failures++;
      $display("FAIL b2b_count: %0d frames, required 2", starts.size());
    end else if (starts[1] - starts[0] != 40) begin
      failures++;
      $display("FAIL b2b_gap: start spacing %0d clocks, required 40",
               starts[1] - starts[0]);
    end

    // error cases
    rd32(32'h10, "rd_unmapped");
    rd32(32'h104, "rd_high_addr");
    wr32(32'h04, 32'hFFFF, "wr_status");
    wr32(32'h08, 32'd1, "wr_baud_1");
    rd32(32'h08, "baud_kept");
    rd32(32'h00, "rd_txdata");
    access(1'b1, 1'b1, 32'h0C, 32'd0, "wr_and_rd");
    rd32(32'h0C, "ctrl_after_both");

    // randomized batches
    for (int it = 0; it < 6; it++) begin
      n_b = $urandom_range(1, DEPTH);
      dv = $urandom_range(2, 6);
      wr32(32'h0C, 32'd0, "rnd_dis");
      wr32(32'h08, ($urandom & 32'hFFFF0000) | dv, "rnd_baud");
      for (int j = 0; j < n_b; j++)
        wr32(32'h00, $urandom, "rnd_push");
      w = $urandom_range(0, 3);
      case (w)
        0: a_r = 32'h10 + 4 * $urandom_range(0, 59);
        1: a_r = $urandom | 32'h100;
        2: a_r = {$urandom_range(0, 63), 2'b01} & 32'hFF;
        default: a_r = 32'h08;
      endcase
      d_r = (w == 3) ? (($urandom & 32'hFFFF0000) | $urandom_range(0, 1))
                     : $urandom;
      access((w == 3) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, a_r, d_r, "rnd_err");
      rd32(32'h04, "rnd_status");
      wr32(32'h0C, ($urandom & ~32'h3) | 32'd1, "rnd_en");
      wait_done(10 * dv * n_b + 60, "rnd_drain");
      rd32(32'h04, "rnd_status_idle");
      rd32(32'h08, "rnd_baud_rd");
    end

    // reset during data bit 3
    wr32(32'h0C, 32'd0, "mid_dis");
    wr32(32'h08, 32'd4, "mid_baud");
    wr32(32'h00, $urandom & 32'hF7, "mid_push0");
    wr32(32'h00, $urandom, "mid_push1");
    wr32(32'h00, $urandom, "mid_push2");
    wr32(32'h0C, 32'd1, "mid_en");
    w = 0;
    while (!(in_frame && cyc >= 17 && cyc <= 19) && w < 300) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 300) begin
      checks++;
      failures++;
      $display("FAIL mid_wait: data bit 3 not reached, in_frame=%0b cyc=%0d",
               in_frame, cyc);
    end
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_tx: tx=%b during reset, required 1", tx);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rd32(32'h04, "status_after_mid_reset");
    rd32(32'h08, "baud_after_mid_reset");
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_ready: %0d accesses never acknowledged, required 0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
